ring_grant_scheduler: RTL and testbench

RING_GRANT_SCHEDULER -- requirements
Module: ring_grant_scheduler

---
 rtl/ring_sched_pkg.sv | 7 +
 rtl/rr_pick.sv | 22 ++
 rtl/ring_grant_scheduler.sv | 51 +++++
 tb/tb_ring_grant_scheduler.sv | 98 +++++++++
 4 files changed

// File: rtl/ring_sched_pkg.sv
// ring_sched_pkg: shared FSM state type, size defaults and pointer reset value for the ring grant scheduler
package ring_sched_pkg;
  localparam int NREQ_DEF = 4;
  localparam int BURST_DEF = 4;
  localparam logic [3:0] PTR_RST = 4'b0001;
  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first asserted req searching upward from one-hot ptr with wrap; ports req, ptr in; pick (one-hot), valid out
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] ptr,
  output logic [NREQ-1:0] pick,
  output logic            valid
);
  logic found;
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++)
      for (int i = 0; i < NREQ; i++)
        if (!found && ptr[i] && req[(i + k) % NREQ]) begin
          pick[(i + k) % NREQ] = 1'b1;
          found = 1'b1;
        end
  end
  assign valid = |req;
endmodule

// File: rtl/ring_grant_scheduler.sv
// ring_grant_scheduler: burst-limited round-robin grant; ports clock, reset, req in; grant, grant_idx, busy out (registered)
module ring_grant_scheduler
  import ring_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int BURST = BURST_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      grant_idx,
  output logic            busy
);
  state_t state, state_n;
  logic [NREQ-1:0] ptr, ptr_n, rot, pick, grant_n;
  logic [3:0] burst_cnt, cnt_n;
  logic [1:0] idx_n;
  logic valid, rel, go;
  // On release the search starts just past the owner, so the pick sees the rotated pointer in the same edge
  rr_pick #(.NREQ(NREQ)) u_pick (.req(req), .ptr(rel ? rot : ptr), .pick(pick), .valid(valid));
  always_comb begin
    rot = {grant[NREQ-2:0], grant[NREQ-1]};
    rel = state == GRANT && (!(|(req & grant)) || burst_cnt == 4'(BURST - 1));
    go = state == IDLE || rel;
    ptr_n = rel ? rot : ptr;
    state_n = go ? (valid ? GRANT : IDLE) : state;
    grant_n = go ? (valid ? pick : '0) : grant;
    cnt_n = go ? 4'd0 : burst_cnt + 4'd1;
    idx_n = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant_n[i]) idx_n = 2'(i);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ptr <= NREQ'(PTR_RST);
      burst_cnt <= '0;
      grant <= '0;
      grant_idx <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      burst_cnt <= cnt_n;
      grant <= grant_n;
      grant_idx <= idx_n;
      busy <= state_n == GRANT;
    end
  end
endmodule

// File: tb/tb_ring_grant_scheduler.sv
// tb_ring_grant_scheduler: directed self-checking bench for ring_grant_scheduler
module tb_ring_grant_scheduler;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic busy;
  int errors = 0;
  int checks = 0;
  ring_grant_scheduler dut (.clock(clock), .reset(reset), .req(req), .grant(grant), .grant_idx(grant_idx), .busy(busy));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] enc(input logic [3:0] g);
    enc = 2'd0;
    for (int i = 0; i < 4; i++)
      if (g[i]) enc = 2'(i);
  endfunction
  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clock);
    #1;
    check("onehot", 8'($countones(grant) <= 1), 8'd1);
    check("idx_enc", 8'(grant_idx), 8'(enc(grant)));
  endtask
  task automatic do_reset;
    reset = 1'b1;
    step(4'b0000);
    reset = 1'b0;
  endtask
  initial begin
    do_reset;
    check("rst_grant", 8'(grant), 8'h0);
    check("rst_busy", 8'(busy), 8'h0);
    check("rst_ptr", 8'(dut.ptr), 8'h1);
    check("rst_cnt", 8'(dut.burst_cnt), 8'h0);
    for (int c = 0; c < 12; c++) begin
      step(4'b0110);
      check("s1_grant", 8'(grant), (c < 4 || c >= 8) ? 8'h2 : 8'h4);
      check("s1_busy", 8'(busy), 8'h1);
    end
    do_reset;
    for (int c = 0; c < 10; c++) begin
      step(4'b1000);
      check("s2_grant", 8'(grant), 8'h8);
      check("s2_cnt", 8'(dut.burst_cnt), 8'(c % 4));
      check("s2_ptr", 8'(dut.ptr), 8'h1);
    end
    do_reset;
    for (int c = 0; c < 2; c++) begin
      step(4'b0001);
      check("s3_grant", 8'(grant), 8'h1);
    end
    step(4'b0000);
    check("s3_drop_grant", 8'(grant), 8'h0);
    check("s3_drop_busy", 8'(busy), 8'h0);
    check("s3_drop_ptr", 8'(dut.ptr), 8'h2);
    for (int c = 0; c < 3; c++) begin
      step(4'b0000);
      check("idle_grant", 8'(grant), 8'h0);
      check("idle_busy", 8'(busy), 8'h0);
    end
    do_reset;
    for (int c = 0; c < 20; c++) begin
      step(4'b1111);
      check("s4_grant", 8'(grant), 8'(4'b0001 << ((c / 4) % 4)));
    end
    do_reset;
    step(4'b0010);
    check("nonown_first", 8'(grant), 8'h2);
    step(4'b1011);
    check("nonown_hold", 8'(grant), 8'h2);
    step(4'b1001);
    check("nonown_rel", 8'(grant), 8'h8);
    check("nonown_ptr", 8'(dut.ptr), 8'h4);
    do_reset;
    step(4'b0100);
    check("s5_grant", 8'(grant), 8'h4);
    reset = 1'b1;
    step(4'b0100);
    check("s5_rst_grant", 8'(grant), 8'h0);
    check("s5_rst_idx", 8'(grant_idx), 8'h0);
    check("s5_rst_busy", 8'(busy), 8'h0);
    check("s5_rst_ptr", 8'(dut.ptr), 8'h1);
    reset = 1'b0;
    step(4'b0100);
    check("s5_after", 8'(grant), 8'h4);
    check("s5_after_busy", 8'(busy), 8'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
